// File: rtl/csr_perf_counter_unit.sv
// csr_perf_counter_unit: mcycle/minstret/hpm counters, event selectors and
// mcountinhibit, accessed by the six Zicsr ops in the EXE stage.
// Ports: clk, rst (sync, active-low); csr_en/stall/funct3/addr/rs1_data/
// zimm/src_zero carry the CSR instruction; retire_cnt and evt drive counting;
// csr_rd_data/csr_illegal are combinational; ovf_flags are sticky wrap bits.
module csr_perf_counter_unit #(
    parameter int NUM_HPM  = 4,
    parameter int NUM_EVT  = 8,
    parameter int RETIRE_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csr_en,
    input  logic                csr_stall,
    input  logic [2:0]          csr_funct3,
    input  logic [11:0]         csr_addr,
    input  logic [31:0]         csr_rs1_data,
    input  logic [4:0]          csr_zimm,
    input  logic                csr_src_zero,
    input  logic [RETIRE_W-1:0] retire_cnt,
    input  logic [NUM_EVT-1:0]  evt,
    output logic [31:0]         csr_rd_data,
    output logic                csr_illegal,
    output logic [NUM_HPM+1:0]  ovf_flags
);

    localparam int NH = (NUM_HPM > 0) ? NUM_HPM : 1;
    // Implemented inhibit bits: CY (0), IR (2), HPM (3..2+NUM_HPM).
    localparam logic [31:0] INH_MASK =
        32'h0000_0005 | (((32'd1 << NUM_HPM) - 32'd1) << 3);

    logic [63:0] mcycle;
    logic [63:0] minstret;
    logic [63:0] hpm     [NH];
    logic [7:0]  hpm_evt [NH];
    logic [31:0] inhibit;

    logic [4:0]  idx;
    logic        is_ro;
    logic        is_m;
    logic        is_hi;
    logic        ctr_range;
    logic        inh_sel;
    logic        evt_sel;
    logic        mapped;
    logic        wr_attempt;
    logic        we;
    logic        wr_ctr;
    logic [31:0] src;
    logic [31:0] old;
    logic [31:0] nv;
    logic [64:0] instret_sum;
    logic [NH-1:0] evt_hit;

    function automatic logic [31:0] half(input logic [63:0] v,
                                         input logic hi);
        return hi ? v[63:32] : v[31:0];
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] v,
                                          input logic hi,
                                          input logic [31:0] d);
        return hi ? {d, v[31:0]} : {v[63:32], d};
    endfunction

    always_comb begin
        idx       = csr_addr[4:0];
        is_ro     = csr_addr[11:8] == 4'hc;
        is_m      = csr_addr[11:8] == 4'hb;
        is_hi     = csr_addr[7];
        // Counter windows are x00..x1f (lo) and x80..x9f (hi); idx 1 is
        // the time CSR, which this unit does not provide.
        ctr_range = (is_ro | is_m) & (csr_addr[6:5] == 2'b00)
                  & (idx != 5'd1);
        inh_sel   = (csr_addr[11:5] == 7'b0011001) & (idx == 5'd0);
        evt_sel   = (csr_addr[11:5] == 7'b0011001) & (idx >= 5'd3);
        mapped    = ctr_range | inh_sel | evt_sel;

        src = csr_funct3[2] ? {27'd0, csr_zimm} : csr_rs1_data;

        old = '0;
        if (ctr_range) begin
            if (idx == 5'd0) old = half(mcycle, is_hi);
            if (idx == 5'd2) old = half(minstret, is_hi);
        end
        if (inh_sel) old = inhibit;
        for (int i = 0; i < NUM_HPM; i++) begin
            if (idx == 5'(i + 3)) begin
                if (ctr_range) old = half(hpm[i], is_hi);
                if (evt_sel)   old = {24'd0, hpm_evt[i]};
            end
        end

        case (csr_funct3[1:0])
            2'b01:   nv = src;
            2'b10:   nv = old | src;
            2'b11:   nv = old & ~src;
            default: nv = old;
        endcase

        // Set/clear with a zero source is a pure read.
        wr_attempt = (csr_funct3[1:0] == 2'b01)
                   | (csr_funct3[1] & ~csr_src_zero);
        csr_illegal = csr_en & (~mapped | (is_ro & wr_attempt));
        we          = csr_en & ~csr_stall & ~csr_illegal & wr_attempt;
        wr_ctr      = we & is_m & ctr_range;
        csr_rd_data = csr_en ? old : 32'd0;

        instret_sum = {1'b0, minstret} + 65'(retire_cnt);

        evt_hit = '0;
        for (int i = 0; i < NUM_HPM; i++) begin
            for (int k = 1; k <= NUM_EVT; k++) begin
                if (hpm_evt[i] == 8'(k)) evt_hit[i] = evt[k-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mcycle    <= '0;
            minstret  <= '0;
            inhibit   <= '0;
            ovf_flags <= '0;
            for (int i = 0; i < NH; i++) begin
                hpm[i]     <= '0;
                hpm_evt[i] <= '0;
            end
        end else begin
            // A written counter takes the write and skips its increment.
            if (wr_ctr && idx == 5'd0) begin
                mcycle <= merge(mcycle, is_hi, nv);
            end else if (!inhibit[0]) begin
                mcycle <= mcycle + 64'd1;
                if (&mcycle) ovf_flags[0] <= 1'b1;
            end

            if (wr_ctr && idx == 5'd2) begin
                minstret <= merge(minstret, is_hi, nv);
            end else if (!inhibit[2]) begin
                minstret <= instret_sum[63:0];
                if (instret_sum[64]) ovf_flags[1] <= 1'b1;
            end

            for (int i = 0; i < NUM_HPM; i++) begin
                if (wr_ctr && idx == 5'(i + 3)) begin
                    hpm[i] <= merge(hpm[i], is_hi, nv);
                end else if (!inhibit[3+i] && evt_hit[i]) begin
                    hpm[i] <= hpm[i] + 64'd1;
                    if (&hpm[i]) ovf_flags[2+i] <= 1'b1;
                end
                if (we && evt_sel && idx == 5'(i + 3)) begin
                    hpm_evt[i] <= nv[7:0];
                end
            end

            if (we && inh_sel) inhibit <= nv & INH_MASK;
        end
    end

endmodule

// File: tb/tb_csr_perf_counter_unit.sv
// tb_csr_perf_counter_unit: scoreboard bench for csr_perf_counter_unit.
// Expected read data / illegal flags are queued at drive, checked at negedge.
module tb_csr_perf_counter_unit;

    logic        clk;
    logic        rst;
    logic        csr_en;
    logic        csr_stall;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [31:0] csr_rs1_data;
    logic [4:0]  csr_zimm;
    logic        csr_src_zero;
    logic [1:0]  retire_cnt;
    logic [7:0]  evt;
    logic [31:0] csr_rd_data;
    logic        csr_illegal;
    logic [5:0]  ovf_flags;

    typedef struct {
        string       tag;
        logic [31:0] rd;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    csr_perf_counter_unit dut (
        .clk          (clk),
        .rst          (rst),
        .csr_en       (csr_en),
        .csr_stall    (csr_stall),
        .csr_funct3   (csr_funct3),
        .csr_addr     (csr_addr),
        .csr_rs1_data (csr_rs1_data),
        .csr_zimm     (csr_zimm),
        .csr_src_zero (csr_src_zero),
        .retire_cnt   (retire_cnt),
        .evt          (evt),
        .csr_rd_data  (csr_rd_data),
        .csr_illegal  (csr_illegal),
        .ovf_flags    (ovf_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.tag, "_rd"}, 64'(csr_rd_data), 64'(e.rd));
            chk({e.tag, "_ill"}, 64'(csr_illegal), 64'(e.ill));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One CSR instruction for one cycle; expectations go to the scoreboard.
    task automatic csr_op(input string tag, input logic [2:0] f3,
                          input logic [11:0] a, input logic [31:0] s,
                          input logic st, input logic [31:0] erd,
                          input logic eill);
        csr_en       = 1'b1;
        csr_funct3   = f3;
        csr_addr     = a;
        csr_rs1_data = s;
        csr_zimm     = s[4:0];
        csr_src_zero = (s == 32'd0);
        csr_stall    = st;
        exp_q.push_back('{tag, erd, eill});
        tick();
        csr_en    = 1'b0;
        csr_stall = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] e, input logic eill);
        csr_op(tag, 3'b010, a, 32'd0, 1'b0, e, eill);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running want=done");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; csr_en = 1'b0; csr_stall = 1'b0;
        csr_funct3 = 3'd0; csr_addr = 12'd0; csr_rs1_data = 32'd0;
        csr_zimm = 5'd0; csr_src_zero = 1'b0; retire_cnt = 2'd0;
        evt = 8'd0;
        repeat (3) tick();
        chk("rst_ovf", 64'(ovf_flags), 64'd0);
        chk("idle_rd", 64'(csr_rd_data), 64'd0);
        rst = 1'b1;

        // Cycle count: 10 edges after release, no pipeline offset.
        repeat (10) tick();
        rd("cyc10", 12'hc00, 32'd10, 1'b0);
        rd("cych0", 12'hc80, 32'd0, 1'b0);

        // Force mcycle to all-ones, then wrap.
        csr_op("wr_mcy_lo", 3'b001, 12'hb00, 32'hffff_ffff, 1'b0,
               32'd12, 1'b0);
        csr_op("wr_mcy_hi", 3'b001, 12'hb80, 32'hffff_ffff, 1'b0,
               32'd0, 1'b0);
        chk("ovf_pre", 64'(ovf_flags), 64'd0);
        repeat (2) tick();
        rd("wrap_lo", 12'hc00, 32'd1, 1'b0);
        chk("ovf_cyc", 64'(ovf_flags), 64'h1);
        rd("wrap_hi", 12'hc80, 32'd0, 1'b0);

        // Retire accounting and inhibit.
        retire_cnt = 2'd3;
        repeat (4) tick();
        retire_cnt = 2'd0;
        rd("ret12", 12'hc02, 32'd12, 1'b0);
        retire_cnt = 2'd1;
        csr_op("inh_set", 3'b110, 12'h320, 32'd4, 1'b0, 32'd0, 1'b0);
        repeat (2) tick();
        rd("ret_frz", 12'hc02, 32'd13, 1'b0);
        rd("cyc_run", 12'hc00, 32'd12, 1'b0);
        rd("inh_rd", 12'h320, 32'd4, 1'b0);
        retire_cnt = 2'd0;
        csr_op("inh_clr", 3'b111, 12'h320, 32'd4, 1'b0, 32'd4, 1'b0);

        // Event counting on hpm0 with selector 2.
        csr_op("evt_sel2", 3'b101, 12'h323, 32'd2, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            evt = 8'h02; tick(); evt = 8'h00; tick();
        end
        for (int i = 0; i < 3; i++) begin
            evt = 8'h01; tick(); evt = 8'h00; tick();
        end
        rd("hpm5", 12'hc03, 32'd5, 1'b0);
        rd("sel_rd", 12'h323, 32'd2, 1'b0);
        csr_op("evt_sel0", 3'b001, 12'h323, 32'd0, 1'b0, 32'd2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            evt = 8'h02; tick(); evt = 8'h00; tick();
        end
        rd("hpm_off", 12'hc03, 32'd5, 1'b0);
        // Selector keeps 8 bits; 9 is beyond NUM_EVT and counts nothing.
        csr_op("evt_sel9", 3'b001, 12'h323, 32'h109, 1'b0, 32'd0, 1'b0);
        evt = 8'hff;
        repeat (2) tick();
        evt = 8'h00;
        rd("sel9_rd", 12'h323, 32'd9, 1'b0);
        rd("hpm_big", 12'hc03, 32'd5, 1'b0);

        // Read-only and unmapped accesses.
        csr_op("ro_wr", 3'b001, 12'hc00, 32'd5, 1'b0, 32'd47, 1'b1);
        rd("ro_keep", 12'hc00, 32'd48, 1'b0);
        rd("unmap", 12'h7c0, 32'd0, 1'b1);

        // Stalled write retried; lands once, skips that cycle's retire.
        retire_cnt = 2'd1;
        csr_op("stl_a", 3'b001, 12'hb02, 32'h100, 1'b1, 32'd13, 1'b0);
        csr_op("stl_b", 3'b001, 12'hb02, 32'h100, 1'b1, 32'd14, 1'b0);
        csr_op("stl_go", 3'b001, 12'hb02, 32'h100, 1'b0, 32'd15, 1'b0);
        repeat (3) tick();
        rd("ret_103", 12'hc02, 32'h103, 1'b0);
        retire_cnt = 2'd0;
        chk("ovf_keep", 64'(ovf_flags), 64'h1);

        // Reset during a CSR write: nothing lands.
        rst          = 1'b0;
        csr_en       = 1'b1;
        csr_funct3   = 3'b001;
        csr_addr     = 12'hb00;
        csr_rs1_data = 32'h55;
        csr_src_zero = 1'b0;
        tick();
        csr_en = 1'b0;
        rst    = 1'b1;
        chk("rst_ovf2", 64'(ovf_flags), 64'd0);
        rd("rst_cyc", 12'hc00, 32'd0, 1'b0);
        rd("rst_sel", 12'h323, 32'd0, 1'b0);

        chk("q_drain", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/csr_perf_counter_unit.md
Name: csr_perf_counter_unit

Overview:
- Generalised user/machine counter CSR unit for the EXE stage.
- Holds mcycle, minstret, NUM_HPM programmable hpm counters with event selectors, and mcountinhibit.
- Executes all six Zicsr ops (CSRRW/S/C, CSRRWI/SI/CI) against these registers, with read-modify-write and write-vs-increment arbitration.
- Retire accounting takes a per-cycle retire count from the pipeline instead of deriving it from hazard and branch signals.

Parameters:
- NUM_HPM, 4, number of hpm counters (hpmcounter3..3+NUM_HPM-1); legal range 0..29.
- NUM_EVT, 8, width of the event input vector.
- RETIRE_W, 2, width of the retire count input (max retires per cycle = 2^RETIRE_W-1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- csr_en  in  1  CSR instruction valid in EXE this cycle.
- csr_stall  in  1  pipeline stall; blocks the CSR write, not the counting.
- csr_funct3  in  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- csr_addr  in  12  CSR address.
- csr_rs1_data  in  32  rs1 operand.
- csr_zimm  in  5  immediate operand for the I forms.
- csr_src_zero  in  1  rs1 index or zimm is zero.
- retire_cnt  in  RETIRE_W  instructions retired this cycle.
- evt  in  NUM_EVT  event pulses; bit k = event k+1.
- csr_rd_data  out  32  old CSR value (combinational).
- csr_illegal  out  1  illegal access (combinational).
- ovf_flags  out  NUM_HPM+2  sticky 64-bit wrap flags: bit0 mcycle, bit1 minstret, bit2+i hpm i.

Behaviour:
- Reset (rst==0 at a clk edge): all counters 0, all mhpmevent 0, mcountinhibit 0, ovf_flags 0.
- csr_rd_data and csr_illegal are outputs of combinational logic only, so they have no reset value.
- Address map:
  - c00/c80 cycle lo/hi; c02/c82 instret lo/hi; c03+i/c83+i hpmcounter i. All read-only.
  - b00/b80 mcycle lo/hi; b02/b82 minstret lo/hi; b03+i/b83+i mhpmcounter i; 320 mcountinhibit; 323+i mhpmevent i. All read/write.
- Any other address, or an hpm index >= NUM_HPM, reads 0.
- Read: csr_rd_data is the pre-write value of the addressed register in the same cycle. It is 0 when csr_en==0.
- Operand: src = csr_rs1_data for funct3[2]==0, else zero-extended csr_zimm.
- New value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- Write enable we = csr_en & ~csr_stall & ~csr_illegal & ~((RS|RC|RSI|RCI) & csr_src_zero). RW/RWI always write.
- csr_illegal = csr_en & (unmapped address | write attempt to a c-range read-only address).
  - RS/RC/RSI/RCI with csr_src_zero to c-range is legal.
  - csr_illegal suppresses the write and does not stall.
- Half writes:
  - lo write replaces bits[31:0] and keeps [63:32].
  - hi write replaces bits[63:32] and keeps [31:0].
  - The write result is the counter's value after the edge; that counter skips its increment in that cycle. Other counters still count.
- mcountinhibit:
  - bit0 inhibits mcycle; bit2 inhibits minstret; bit 3+i inhibits hpm i.
  - bit1 and bits above 2+NUM_HPM read 0 and ignore writes.
  - A write to mcountinhibit takes effect from the next cycle.
- Increments (uninhibited, not written):
  - mcycle +1 every cycle.
  - minstret +retire_cnt, zero-extended.
  - hpm i +1 when mhpmevent i = k with 1<=k<=NUM_EVT and evt[k-1]==1.
  - mhpmevent values 0 or >NUM_EVT count nothing.
- mhpmevent is 8 bits wide: writes keep bits[7:0]; reads zero-extend.
- Wrap: 64-bit modulo. When an increment carries out of bit 63, the matching ovf_flags bit sets and stays set until reset. A CSR write does not set or clear it.
- Stall: counters keep counting during csr_stall; only the CSR write is held off. The same instruction retried when the stall releases then writes exactly once.
- Reset mid-instruction: reset wins; no write lands.

Test Plan:
- Release reset, idle 10 cycles, read c00 (CSRRS, src_zero) -> rd_data = 10 ± pipeline offset stated by the bench; c80 -> 0; csr_illegal = 0.
- CSRRW b00 with rs1=0xFFFF_FFFF, then CSRRW b80 with 0xFFFF_FFFF; wait 2 cycles -> mcycle wraps to 0x0000_0000_0000_0001, ovf_flags[0]=1.
- retire_cnt = 3 for 4 cycles -> minstret = 12. Then CSRRSI 320 with zimm=4 -> minstret frozen at its post-write-cycle value while cycle keeps counting.
- CSRRWI 323 with zimm=2, pulse evt[1] 5 times and evt[0] 3 times -> hpmcounter3 = 5. Write 323 with 0 -> further evt[1] pulses do not count.
- CSRRW c00 with csr_src_zero=0 -> csr_illegal=1, cycle is not modified. CSRRS c00 with csr_src_zero=1 -> legal read.
- CSRRW b02 with 0x100 while retire_cnt=1 and csr_stall=1 for 2 cycles, then stall released -> minstret lo = 0x100 exactly once, that cycle's retire is not added, and it counts +1 per cycle afterwards.
